// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state
// encoding, parity-mode constants and the default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side valid/ready word channel into the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Tx_Data;
    logic                 Tx_Valid;
    logic                 Tx_Ready;

    modport master (output Tx_Data, output Tx_Valid, input  Tx_Ready);
    modport slave  (input  Tx_Data, input  Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while not cleared and flags
// the last cycle of each bit with o_tick. Shared by the TX and RX paths.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap && !i_clear;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes words over a valid/ready channel and shifts them
// out LSB-first as start, data, optional parity and stop bits on TX.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = UART_PARITY_EVEN,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    uart_tx_if.slave   Tx_Bus,
    output logic       Tx_Busy,
    output logic       TX
);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;

    logic w_tick;
    logic w_baud_clear;
    logic w_ready;
    logic w_accept;

    assign w_baud_clear = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_clear (w_baud_clear),
        .o_tick  (w_tick)
    );

    // Ready in the last stop cycle lets the next start bit follow with no gap.
    assign w_ready  = (r_state == IDLE) ||
                      ((r_state == STOP) && w_tick && (r_bit_cnt == LAST_STOP));
    assign w_accept = Tx_Bus.Tx_Valid && w_ready;

    assign Tx_Bus.Tx_Ready = w_ready;
    assign Tx_Busy         = r_busy;
    assign TX              = r_tx;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            r_state   <= START;
            r_shift   <= Tx_Bus.Tx_Data;
            r_parity  <= (^Tx_Bus.Tx_Data) ^ PARITY_ODD;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: if (w_tick) begin
                    r_state   <= DATA;
                    r_tx      <= r_shift[0];
                    r_bit_cnt <= '0;
                end
                DATA: if (w_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        r_bit_cnt <= '0;
                        if (PARITY_EN) begin
                            r_state <= PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shift   <= r_shift >> 1;
                        r_tx      <= r_shift[1];
                    end
                end
                PARITY: if (w_tick) begin
                    r_state   <= STOP;
                    r_tx      <= 1'b1;
                    r_bit_cnt <= '0;
                end
                STOP: if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
